sd_dma_read: RTL and testbench
==============================

// Module: sd_dma_read
// PURPOSE
// Memory-to-SD read DMA: the read counterpart of the SD write DMA. Issues word reads on the
// shared memory bus (bank/address request, in-order i_ack data return) and pushes returned
// words into the SD TX FIFO. Bounds outstanding reads with an internal return buffer so
// acked data is never dropped while the TX FIFO is full. Sits between the SD register file and the bus arbiter.
// PARAMETERS
// BUF_DEPTH  4  return-buffer entries and max reads in flight plus buffered; power of 2, >=2
// PORTS
// i_clk                    in   1   clock
// i_reset_n                in   1   asynchronous reset, active low
// i_dma_bank               in   4   start bank
// i_dma_address            in   24  start word address
// i_dma_length             in   18  transfer length in 32-bit words
// i_dma_load_bank_address  in   1   load bank/address (ignored while busy)
// i_dma_load_length        in   1   load length (ignored while busy)
// i_dma_start              in   1   start transfer (ignored while busy)
// i_dma_stop               in   1   abort transfer
// o_dma_busy               out  1   transfer or drain in progress
// o_dma_left               out  18  words not yet pushed to TX FIFO
// o_tx_fifo_push           out  1   push o_tx_fifo_data this cycle
// i_tx_fifo_full           in   1   TX FIFO full
// o_tx_fifo_data           out  32  word to push (return-buffer head)
// o_request                out  1   bus read request
// i_busy                   in   1   bus cannot accept request this cycle
// i_ack                    in   1   read data valid on i_data
// o_bank                   out  4   request bank
// o_address                out  24  request word address
// i_data                   in   32  read data
// BEHAVIOUR
// - Reset (async, i_reset_n=0): state IDLE; all counters, buffer pointers, o_bank, o_address,
//   o_dma_left cleared to 0; o_dma_busy=0, o_request=0, o_tx_fifo_push=0. Mid-transfer reset aborts at once.
// - Loads in IDLE: bank/address and length registers captured on the cycle after the strobe.
//   Length loads both req_left (words to request) and o_dma_left (words to push).
// - States: IDLE -> RUN on i_dma_start && !i_dma_stop && length!=0; start with length 0: stay IDLE, no requests.
//   RUN -> IDLE when req_left==0, outstanding==0, buffer empty (o_dma_left==0).
//   RUN/any busy -> ABORT on i_dma_stop; ABORT -> IDLE when outstanding==0.
//   o_dma_busy=1 in RUN and ABORT. i_dma_stop in IDLE: no effect; stop beats start same cycle.
// - Accept: acc = o_request && !i_busy. o_request = RUN && req_left!=0 && (outstanding+buf_count) < BUF_DEPTH
//   (combinational; outstanding/buf_count are log2(BUF_DEPTH)+1 bits).
// - On acc: o_address <= o_address+1 (24-bit wrap 0xFFFFFF->0, bank unchanged); req_left--; outstanding++.
// - On i_ack with outstanding!=0: outstanding--; in RUN write i_data to buffer tail, buf_count++;
//   in ABORT discard data. i_ack with outstanding==0: ignored (protocol violation, no state change).
// - acc and i_ack same cycle: outstanding unchanged. Write and push same cycle: buf_count unchanged.
// - Push: o_tx_fifo_push = RUN && buf_count!=0 && !i_tx_fifo_full; o_tx_fifo_data = buffer head (0 latency).
//   On push: head advances, buf_count--, o_dma_left--. Buffer never overflows by construction of o_request.
// - ABORT: buffer flushed on entry (buf_count<=0); o_dma_left holds its value at stop for software readback.
// - Latency: first request the cycle after start; ack-to-push minimum 1 cycle.
// TESTING
// - Load bank 2, addr 0x000010, len 3, start, i_busy=0, ack 2 cycles after each accept -> requests at
//   0x10,0x11,0x12; 3 pushes in order; o_dma_left 3->0; busy drops after last push.
// - len 8, BUF_DEPTH=4, i_tx_fifo_full=1 held -> exactly 4 accepts, o_request then 0; release full ->
//   4 pushes, remaining 4 requests issue; total 8 words, data order preserved.
// - Start addr 0xFFFFFF len 2 -> second request at 0x000000, o_bank unchanged.
// - Stop with 2 reads outstanding -> o_request=0 next cycle, busy held until both acks, no pushes
//   after stop, o_dma_left frozen; then IDLE.
// - i_reset_n low mid-RUN with outstanding reads -> all outputs 0 immediately; later acks ignored; load/start works afterwards.
// - Start with len 0, and load/start strobes while busy -> no request, registers unchanged.

Source files
------------

// File: rtl/sd_dma_read.sv
// sd_dma_read: memory-to-SD read DMA. Issues word reads on the shared bus,
// parks returned words in a small return buffer and drains it into the SD
// TX FIFO. Reads in flight plus buffered words never exceed BUF_DEPTH, so an
// acked word always has a slot even while the TX FIFO is full.
module sd_dma_read #(
  parameter int BUF_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [3:0]  i_dma_bank,
  input  logic [23:0] i_dma_address,
  input  logic [17:0] i_dma_length,
  input  logic        i_dma_load_bank_address,
  input  logic        i_dma_load_length,
  input  logic        i_dma_start,
  input  logic        i_dma_stop,
  output logic        o_dma_busy,
  output logic [17:0] o_dma_left,
  output logic        o_tx_fifo_push,
  input  logic        i_tx_fifo_full,
  output logic [31:0] o_tx_fifo_data,
  output logic        o_request,
  input  logic        i_busy,
  input  logic        i_ack,
  output logic [3:0]  o_bank,
  output logic [23:0] o_address,
  input  logic [31:0] i_data
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;

  // state   | meaning
  // S_IDLE  | waiting for start; bank/address/length loads accepted
  // S_RUN   | issuing reads, buffering acks, pushing into TX FIFO
  // S_ABORT | stopped; buffer flushed, waiting for in-flight acks to drain
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  state_t        state_q;
  logic [3:0]    bank_q;
  logic [23:0]   addr_q;
  logic [17:0]   req_left_q;
  logic [17:0]   dma_left_q;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] buf_count_q, buf_count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [31:0]   buf_q [BUF_DEPTH];
  logic [CW:0]   in_use;
  logic          run;
  logic          acc;
  logic          ack_v;
  logic          wr;
  logic          push;

  assign run    = (state_q == S_RUN);
  assign in_use = {1'b0, outstanding_q} + {1'b0, buf_count_q};

  // A new read is only offered when its data is guaranteed a buffer slot.
  assign o_request = run && (req_left_q != '0) && (in_use < (CW+1)'(BUF_DEPTH));
  assign acc       = o_request && !i_busy;
  // Acks with nothing outstanding are stray and must not disturb any state.
  assign ack_v     = i_ack && (outstanding_q != '0);
  assign wr        = ack_v && run;
  assign push      = run && (buf_count_q != '0) && !i_tx_fifo_full;

  assign o_tx_fifo_push = push;
  assign o_tx_fifo_data = buf_q[head_q];
  assign o_dma_busy     = (state_q != S_IDLE);
  assign o_bank         = bank_q;
  assign o_address      = addr_q;
  assign o_dma_left     = dma_left_q;

  // Next values of the in-flight count and the return-buffer pointers
  always_comb begin
    outstanding_d = outstanding_q;
    if (acc && !ack_v) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!acc && ack_v) begin
      outstanding_d = outstanding_q - 1'b1;
    end
    buf_count_d = buf_count_q;
    if (wr && !push) begin
      buf_count_d = buf_count_q + 1'b1;
    end else if (!wr && push) begin
      buf_count_d = buf_count_q - 1'b1;
    end
    head_d = push ? head_q + 1'b1 : head_q;
    tail_d = wr ? tail_q + 1'b1 : tail_q;
  end

  // Return-buffer storage; contents need no reset since buf_count gates use
  always_ff @(posedge i_clk) begin
    if (wr) begin
      buf_q[tail_q] <= i_data;
    end
  end

  // Transfer FSM with its address, length and buffer bookkeeping
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= S_IDLE;
      bank_q        <= '0;
      addr_q        <= '0;
      req_left_q    <= '0;
      dma_left_q    <= '0;
      outstanding_q <= '0;
      buf_count_q   <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      case (state_q)
        S_IDLE: begin
          if (i_dma_load_bank_address) begin
            bank_q <= i_dma_bank;
            addr_q <= i_dma_address;
          end
          if (i_dma_load_length) begin
            req_left_q <= i_dma_length;
            dma_left_q <= i_dma_length;
          end
          if (i_dma_start && !i_dma_stop && (req_left_q != '0)) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (acc) begin
            addr_q     <= addr_q + 24'd1;
            req_left_q <= req_left_q - 18'd1;
          end
          if (push) begin
            dma_left_q <= dma_left_q - 18'd1;
          end
          if (i_dma_stop) begin
            // Buffered words are dropped; o_dma_left keeps the count for readback.
            state_q     <= S_ABORT;
            buf_count_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
          end else begin
            buf_count_q <= buf_count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            if ((req_left_q == '0) && (outstanding_q == '0) && (buf_count_q == '0)) begin
              state_q <= S_IDLE;
            end
          end
        end
        S_ABORT: begin
          if (outstanding_q == '0) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_dma_read.sv
// tb_sd_dma_read: directed scenarios plus randomized transfers for sd_dma_read.
// A bus model returns random data in order after a random delay; the reference
// is a queue of returned words that must come out of the TX FIFO port in order,
// with request addresses following start address + accept index.
module tb_sd_dma_read;
  localparam int BUF_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  i_dma_bank;
  logic [23:0] i_dma_address;
  logic [17:0] i_dma_length;
  logic        i_dma_load_bank_address;
  logic        i_dma_load_length;
  logic        i_dma_start;
  logic        i_dma_stop;
  logic        o_dma_busy;
  logic [17:0] o_dma_left;
  logic        o_tx_fifo_push;
  logic        i_tx_fifo_full;
  logic [31:0] o_tx_fifo_data;
  logic        o_request;
  logic        i_busy;
  logic        i_ack;
  logic [3:0]  o_bank;
  logic [23:0] o_address;
  logic [31:0] i_data;

  sd_dma_read #(.BUF_DEPTH(BUF_DEPTH)) dut (
    .i_clk                   (clk),
    .i_reset_n               (rst_n),
    .i_dma_bank              (i_dma_bank),
    .i_dma_address           (i_dma_address),
    .i_dma_length            (i_dma_length),
    .i_dma_load_bank_address (i_dma_load_bank_address),
    .i_dma_load_length       (i_dma_load_length),
    .i_dma_start             (i_dma_start),
    .i_dma_stop              (i_dma_stop),
    .o_dma_busy              (o_dma_busy),
    .o_dma_left              (o_dma_left),
    .o_tx_fifo_push          (o_tx_fifo_push),
    .i_tx_fifo_full          (i_tx_fifo_full),
    .o_tx_fifo_data          (o_tx_fifo_data),
    .o_request               (o_request),
    .i_busy                  (i_busy),
    .i_ack                   (i_ack),
    .o_bank                  (o_bank),
    .o_address               (o_address),
    .i_data                  (i_data)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          push_cnt = 0;
  int          model_out = 0;
  logic        running = 1'b0;
  logic [3:0]  m_bank = '0;
  logic [23:0] m_addr = '0;
  int          m_len = 0;
  logic [31:0] exp_q[$];
  int          ack_q[$];
  int          ack_min = 1;
  int          ack_max = 1;
  int          busy_pct = 0;
  int          full_mode = 0;
  int          acc_limit = 1000000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at negedge, then drive the bus/FIFO inputs after posedge.
  task automatic tick();
    int t;
    logic [23:0] ea;
    @(negedge clk);
    if (!running) begin
      chk("req_idle", {63'd0, o_request}, 64'd0);
      chk("push_idle", {63'd0, o_tx_fifo_push}, 64'd0);
    end
    if (o_request && !i_busy) begin
      ea = m_addr + 24'(acc_cnt);
      chk("req_addr", {40'd0, o_address}, {40'd0, ea});
      chk("req_bank", {60'd0, o_bank}, {60'd0, m_bank});
      acc_cnt++;
      model_out++;
      t = cyc + int'($urandom_range(ack_max, ack_min));
      if (ack_q.size() > 0 && t <= ack_q[$]) t = ack_q[$] + 1;
      ack_q.push_back(t);
    end
    if (o_tx_fifo_push && running) begin
      chk("push_full", {63'd0, i_tx_fifo_full}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("push_extra", {63'd0, o_tx_fifo_push}, 64'd0);
      end else begin
        chk("push_data", {32'd0, o_tx_fifo_data}, {32'd0, exp_q.pop_front()});
        chk("push_left", {46'd0, o_dma_left}, 64'(m_len - push_cnt));
      end
      push_cnt++;
    end
    if (running) chk("flow", 64'((acc_cnt - push_cnt) <= BUF_DEPTH), 64'd1);
    if (i_ack && model_out > 0) begin
      model_out--;
      if (running) exp_q.push_back(i_data);
    end
    @(posedge clk);
    #1;
    cyc++;
    i_busy = (acc_cnt >= acc_limit) || (int'($urandom_range(99, 0)) < busy_pct);
    if (full_mode == 1) i_tx_fifo_full = 1'b1;
    else if (full_mode == 2) i_tx_fifo_full = 1'($urandom_range(1, 0));
    else i_tx_fifo_full = 1'b0;
    if (ack_q.size() > 0 && ack_q[0] <= cyc) begin
      void'(ack_q.pop_front());
      i_ack  = 1'b1;
      i_data = $urandom;
    end else begin
      i_ack = 1'b0;
    end
  endtask

  task automatic load(input logic [3:0] b, input logic [23:0] a, input logic [17:0] l);
    i_dma_bank = b;
    i_dma_address = a;
    i_dma_length = l;
    i_dma_load_bank_address = 1'b1;
    i_dma_load_length = 1'b1;
    tick();
    i_dma_load_bank_address = 1'b0;
    i_dma_load_length = 1'b0;
    m_bank = b;
    m_addr = a;
    m_len = int'(l);
  endtask

  task automatic start_xfer();
    acc_cnt = 0;
    push_cnt = 0;
    exp_q.delete();
    running = (m_len != 0);
    i_dma_start = 1'b1;
    tick();
    i_dma_start = 1'b0;
  endtask

  task automatic run_until_idle(input int bound);
    int n = 0;
    while (o_dma_busy && n < bound) begin
      tick();
      n++;
    end
    chk("idle_timeout", {63'd0, o_dma_busy}, 64'd0);
    running = 1'b0;
  endtask

  task automatic end_checks();
    chk("accepts", 64'(acc_cnt), 64'(m_len));
    chk("pushes", 64'(push_cnt), 64'(m_len));
    chk("left_zero", {46'd0, o_dma_left}, 64'd0);
    chk("exp_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_acc(input int n, input int bound);
    int k = 0;
    while (acc_cnt < n && k < bound) begin
      tick();
      k++;
    end
    chk("wait_acc", 64'(acc_cnt >= n), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    i_dma_bank = '0;
    i_dma_address = '0;
    i_dma_length = '0;
    i_dma_load_bank_address = 1'b0;
    i_dma_load_length = 1'b0;
    i_dma_start = 1'b0;
    i_dma_stop = 1'b0;
    i_tx_fifo_full = 1'b0;
    i_busy = 1'b0;
    i_ack = 1'b0;
    i_data = '0;

    // Reset state
    tick();
    tick();
    chk("rst_busy", {63'd0, o_dma_busy}, 64'd0);
    chk("rst_req", {63'd0, o_request}, 64'd0);
    chk("rst_push", {63'd0, o_tx_fifo_push}, 64'd0);
    chk("rst_left", {46'd0, o_dma_left}, 64'd0);
    chk("rst_addr", {40'd0, o_address}, 64'd0);
    chk("rst_bank", {60'd0, o_bank}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic 3-word transfer, ack 2 cycles after accept
    ack_min = 2; ack_max = 2; busy_pct = 0; full_mode = 0;
    load(4'd2, 24'h000010, 18'd3);
    chk("t1_left_loaded", {46'd0, o_dma_left}, 64'd3);
    chk("t1_idle", {63'd0, o_dma_busy}, 64'd0);
    start_xfer();
    chk("t1_busy", {63'd0, o_dma_busy}, 64'd1);
    chk("t1_first_req", {63'd0, o_request}, 64'd1);
    run_until_idle(60);
    end_checks();
    chk("t1_addr_end", {40'd0, o_address}, 64'h13);

    // Full FIFO held: only BUF_DEPTH reads may be in flight/buffered
    ack_min = 1; ack_max = 3; full_mode = 1;
    load(4'd5, 24'h000100, 18'd8);
    start_xfer();
    repeat (20) tick();
    chk("t2_accepts_capped", 64'(acc_cnt), 64'(BUF_DEPTH));
    chk("t2_req_low", {63'd0, o_request}, 64'd0);
    chk("t2_left_held", {46'd0, o_dma_left}, 64'd8);
    full_mode = 0;
    run_until_idle(100);
    end_checks();

    // Address wrap, bank unchanged
    ack_min = 1; ack_max = 2;
    load(4'd7, 24'hFFFFFF, 18'd2);
    start_xfer();
    run_until_idle(60);
    end_checks();
    chk("t3_addr_wrap", {40'd0, o_address}, 64'h000001);
    chk("t3_bank", {60'd0, o_bank}, 64'd7);

    // Stop with two reads in flight
    ack_min = 4; ack_max = 4; full_mode = 1; acc_limit = 2;
    load(4'd3, 24'h000200, 18'd8);
    start_xfer();
    wait_acc(2, 20);
    i_dma_stop = 1'b1;
    tick();
    i_dma_stop = 1'b0;
    running = 1'b0;
    full_mode = 0;
    acc_limit = 1000000;
    chk("t4_out_at_stop", 64'(model_out), 64'd2);
    for (int k = 0; k < 20 && model_out > 0; k++) begin
      chk("t4_busy_held", {63'd0, o_dma_busy}, 64'd1);
      chk("t4_req_off", {63'd0, o_request}, 64'd0);
      chk("t4_left_frozen", {46'd0, o_dma_left}, 64'd8);
      tick();
    end
    chk("t4_acks_done", 64'(model_out), 64'd0);
    run_until_idle(10);
    chk("t4_left_after", {46'd0, o_dma_left}, 64'd8);
    chk("t4_no_push", 64'(push_cnt), 64'd0);

    // Asynchronous reset mid-transfer with reads outstanding
    ack_min = 4; ack_max = 4;
    load(4'd1, 24'h000300, 18'd8);
    start_xfer();
    wait_acc(2, 20);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", {63'd0, o_dma_busy}, 64'd0);
    chk("t5_req", {63'd0, o_request}, 64'd0);
    chk("t5_push", {63'd0, o_tx_fifo_push}, 64'd0);
    chk("t5_left", {46'd0, o_dma_left}, 64'd0);
    chk("t5_addr", {40'd0, o_address}, 64'd0);
    chk("t5_bank", {60'd0, o_bank}, 64'd0);
    running = 1'b0;
    model_out = 0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t5_stays_idle", {63'd0, o_dma_busy}, 64'd0);
      chk("t5_left_zero", {46'd0, o_dma_left}, 64'd0);
    end
    ack_min = 1; ack_max = 3;
    load(4'd9, 24'h000ABC, 18'd5);
    start_xfer();
    run_until_idle(80);
    end_checks();

    // Zero length start, then strobes while busy
    load(4'd4, 24'h000400, 18'd0);
    start_xfer();
    repeat (5) tick();
    chk("t6_len0_idle", {63'd0, o_dma_busy}, 64'd0);
    chk("t6_len0_noacc", 64'(acc_cnt), 64'd0);
    full_mode = 1;
    load(4'd6, 24'h000500, 18'd4);
    start_xfer();
    repeat (3) tick();
    i_dma_bank = 4'hF;
    i_dma_address = 24'hFFF000;
    i_dma_length = 18'd99;
    i_dma_load_bank_address = 1'b1;
    i_dma_load_length = 1'b1;
    i_dma_start = 1'b1;
    tick();
    i_dma_load_bank_address = 1'b0;
    i_dma_load_length = 1'b0;
    i_dma_start = 1'b0;
    chk("t6_left_kept", {46'd0, o_dma_left}, 64'd4);
    chk("t6_bank_kept", {60'd0, o_bank}, 64'd6);
    full_mode = 0;
    run_until_idle(80);
    end_checks();
    repeat (5) tick();
    chk("t6_no_restart", {63'd0, o_dma_busy}, 64'd0);

    // Randomized transfers
    busy_pct = 30; full_mode = 2; ack_min = 1; ack_max = 4;
    for (int r = 0; r < 6; r++) begin
      logic [23:0] a;
      a = (r % 2 == 0) ? (24'hFFFFFF - 24'($urandom_range(5, 0))) : 24'($urandom);
      load(4'($urandom), a, 18'($urandom_range(40, 1)));
      start_xfer();
      run_until_idle(2000);
      end_checks();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
